// File: rtl/sd_credit_tx.sv
// Purpose : credit-based transmit stage; turns a srdy/drdy upstream into a valid/credit downstream.
// Latency : 1 cycle from accepted c_data to p_vld/p_data.
// Backpressure: c_drdy drops while no credits remain; each p_credit pulse returns one slot.
//
// Ports:
//    clk         single clock, all state on its rising edge
//    reset_n     asynchronous active-low reset
//    c_srdy      upstream has a word on c_data
//    c_drdy      block accepts c_data this cycle (credit_cnt != 0)
//    c_data      upstream payload
//    p_vld       one-cycle pulse per word sent toward the receiver
//    p_data      registered payload, holds its value between pulses
//    p_credit    one-cycle pulse from the receiver freeing one slot
//    credit_cnt  receiver slots currently available to this sender
//    err_ovf     sticky flag: receiver returned a credit we never lent out
module sd_credit_tx #(
   parameter int width   = 8,
   parameter int credits = 4
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                c_srdy,
   output logic                                c_drdy,
   input  logic [width-1:0]                    c_data,
   output logic                                p_vld,
   output logic [width-1:0]                    p_data,
   input  logic                                p_credit,
   output logic [$clog2(credits+1)-1:0]        credit_cnt,
   output logic                                err_ovf
);

   localparam int cw = $clog2(credits+1);
   localparam logic [cw-1:0] max_cnt = cw'(credits);

   logic xfer;

   // c_drdy depends only on the registered counter, so p_credit can never
   // bypass into the same cycle: a returned credit is usable one cycle later.
   assign c_drdy = (credit_cnt != '0);
   assign xfer   = c_srdy & c_drdy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_vld      <= 1'b0;
         p_data     <= '0;
         credit_cnt <= max_cnt;
         err_ovf    <= 1'b0;
      end else begin
         p_vld <= xfer;
         if (xfer) begin
            p_data <= c_data;
         end

         // A send and a return in the same cycle cancel out, even when the
         // counter is full, because the send has just consumed the slot the
         // return refills.
         unique case ({xfer, p_credit})
            2'b10: credit_cnt <= credit_cnt - 1'b1;
            2'b01: begin
               if (credit_cnt == max_cnt) begin
                  // Receiver handed back more than it was given: keep the
                  // counter pinned and latch the error until reset.
                  err_ovf <= 1'b1;
               end else begin
                  credit_cnt <= credit_cnt + 1'b1;
               end
            end
            default: credit_cnt <= credit_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_credit_tx.sv
module tb_sd_credit_tx;

   localparam int W  = 8;
   localparam int CR = 4;
   localparam int CW = $clog2(CR+1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          c_srdy = 1'b0;
   logic          c_drdy;
   logic [W-1:0]  c_data = '0;
   logic          p_vld;
   logic [W-1:0]  p_data;
   logic          p_credit = 1'b0;
   logic [CW-1:0] credit_cnt;
   logic          err_ovf;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];   // words the model says were accepted, in order
   logic [W-1:0] rx_q[$];    // words held by the receiver model

   always #5 clk = ~clk;

   sd_credit_tx #(.width(W), .credits(CR)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .c_srdy     (c_srdy),
      .c_drdy     (c_drdy),
      .c_data     (c_data),
      .p_vld      (p_vld),
      .p_data     (p_data),
      .p_credit   (p_credit),
      .credit_cnt (credit_cnt),
      .err_ovf    (err_ovf)
   );

   // Inputs change 1 ns after a rising edge; outputs are sampled there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      c_srdy   = 1'b0;
      p_credit = 1'b0;
      c_data   = '0;
      reset_n  = 1'b0;
      step();
      reset_n  = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL reset_p_vld got %b want 0", p_vld); end
      checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data got %h want 00", p_data); end
      checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL reset_credit_cnt got %0d want 4", credit_cnt); end
      checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf got %b want 0", err_ovf); end
      checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL reset_c_drdy got %b want 1", c_drdy); end
   endtask

   // Six cycles of c_srdy with no credit return: four words go out back to back.
   task automatic test_drain();
      logic [W-1:0] last;
      logic [CW-1:0] ec;
      do_reset();
      last = 8'h00;
      for (int i = 0; i < 6; i++) begin
         c_srdy = 1'b1;
         c_data = 8'h10 + W'(i);
         step();
         if (i < 4) last = 8'h10 + W'(i);
         ec = (i < 4) ? CW'(3 - i) : CW'(0);
         checks++; if (p_vld !== (i < 4)) begin errors++; $display("FAIL drain_p_vld[%0d] got %b want %b", i, p_vld, (i < 4)); end
         checks++; if (p_data !== last) begin errors++; $display("FAIL drain_p_data[%0d] got %h want %h", i, p_data, last); end
         checks++; if (credit_cnt !== ec) begin errors++; $display("FAIL drain_credit_cnt[%0d] got %0d want %0d", i, credit_cnt, ec); end
      end
      checks++; if (c_drdy !== 1'b0) begin errors++; $display("FAIL drain_c_drdy got %b want 0", c_drdy); end
   endtask

   // Continues from an empty counter: one credit returns while c_srdy is
   // already high; the send may only happen the cycle after.
   task automatic test_credit_return();
      c_srdy   = 1'b1;
      c_data   = 8'h55;
      p_credit = 1'b1;
      step();
      p_credit = 1'b0;
      checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL ret_no_bypass got p_vld=%b want 0", p_vld); end
      checks++; if (credit_cnt !== 3'd1) begin errors++; $display("FAIL ret_credit_cnt got %0d want 1", credit_cnt); end
      checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL ret_c_drdy got %b want 1", c_drdy); end
      c_data = 8'h77;
      step();
      c_srdy = 1'b0;
      checks++; if (p_vld !== 1'b1) begin errors++; $display("FAIL ret_p_vld got %b want 1", p_vld); end
      checks++; if (p_data !== 8'h77) begin errors++; $display("FAIL ret_p_data got %h want 77", p_data); end
      checks++; if (credit_cnt !== 3'd0) begin errors++; $display("FAIL ret_credit_cnt_after got %0d want 0", credit_cnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      c_srdy   = 1'b1;
      c_data   = 8'h3C;
      p_credit = 1'b1;
      step();
      c_srdy   = 1'b0;
      p_credit = 1'b0;
      checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL simul_credit_cnt got %0d want 4", credit_cnt); end
      checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL simul_err_ovf got %b want 0", err_ovf); end
      checks++; if (p_vld !== 1'b1) begin errors++; $display("FAIL simul_p_vld got %b want 1", p_vld); end
      checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL simul_p_data got %h want 3c", p_data); end
   endtask

   task automatic test_overflow();
      do_reset();
      p_credit = 1'b1;
      step();
      p_credit = 1'b0;
      checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL ovf_credit_cnt got %0d want 4", credit_cnt); end
      checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_err_set got %b want 1", err_ovf); end
      for (int i = 0; i < 10; i++) begin
         c_srdy = (i % 3) == 0;   // normal traffic must not clear the flag
         c_data = W'(i);
         step();
         checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky[%0d] got %b want 1", i, err_ovf); end
      end
      c_srdy = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      p_credit = 1'b1;          // set err_ovf first so reset has something to clear
      step();
      p_credit = 1'b0;
      c_srdy   = 1'b1;
      c_data   = 8'hA5;
      step();
      step();
      checks++; if (p_vld !== 1'b1 || p_data !== 8'hA5) begin errors++; $display("FAIL areset_pre got vld=%b data=%h want 1/a5", p_vld, p_data); end
      #3;
      reset_n = 1'b0;           // mid-cycle, no clock edge involved
      #1;
      checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL areset_p_vld got %b want 0", p_vld); end
      checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL areset_p_data got %h want 00", p_data); end
      checks++; if (credit_cnt !== 3'd4) begin errors++; $display("FAIL areset_credit_cnt got %0d want 4", credit_cnt); end
      checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL areset_err_ovf got %b want 0", err_ovf); end
      checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL areset_c_drdy got %b want 1", c_drdy); end
      step();                   // edge with reset held and c_srdy high
      checks++; if (p_vld !== 1'b0) begin errors++; $display("FAIL areset_held_p_vld got %b want 0", p_vld); end
      reset_n = 1'b1;
      c_data  = 8'h5A;
      step();
      c_srdy  = 1'b0;
      checks++; if (p_vld !== 1'b1 || p_data !== 8'h5A) begin errors++; $display("FAIL areset_first_xfer got vld=%b data=%h want 1/5a", p_vld, p_data); end
      checks++; if (credit_cnt !== 3'd3) begin errors++; $display("FAIL areset_first_cnt got %0d want 3", credit_cnt); end
   endtask

   // Random traffic against a receiver holding CR slots. The model only
   // tracks how many words are outstanding at the receiver side.
   task automatic test_random();
      int outstanding;
      logic exp_xfer;
      logic [W-1:0] sent;
      logic [W-1:0] got;
      do_reset();
      exp_q.delete();
      rx_q.delete();
      outstanding = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         c_srdy = ($urandom_range(0, 9) < 7);
         c_data = W'($urandom);
         p_credit = 1'b0;
         if (rx_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            p_credit = 1'b1;
            void'(rx_q.pop_front());
         end
         exp_xfer = c_srdy && (outstanding < CR);
         sent = c_data;
         step();
         if (exp_xfer) exp_q.push_back(sent);
         outstanding = outstanding + int'(exp_xfer) - int'(p_credit);
         checks++; if (p_vld !== exp_xfer) begin errors++; $display("FAIL rand_p_vld cyc %0d got %b want %b", cyc, p_vld, exp_xfer); end
         if (p_vld === 1'b1) begin
            got = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (p_data !== got) begin errors++; $display("FAIL rand_order cyc %0d got %h want %h", cyc, p_data, got); end
            rx_q.push_back(p_data);
            checks++; if (rx_q.size() > CR) begin errors++; $display("FAIL rand_rx_overflow cyc %0d got %0d words want <= %0d", cyc, rx_q.size(), CR); end
         end
         checks++; if (credit_cnt !== CW'(CR - outstanding)) begin errors++; $display("FAIL rand_credit_cnt cyc %0d got %0d want %0d", cyc, credit_cnt, CR - outstanding); end
         checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL rand_err_ovf cyc %0d got %b want 0", cyc, err_ovf); end
      end
      c_srdy   = 1'b0;
      p_credit = 1'b0;
   endtask

   initial begin
      test_reset();
      test_drain();
      test_credit_return();
      test_simultaneous();
      test_overflow();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_credit_tx.md
SD_CREDIT_TX -- requirements
Module: sd_credit_tx

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning data payload width in bits.
REQ-002 The block SHALL have parameter credits, default 4, legal 1..255, meaning the number of receiver buffer slots (initial credit count).
REQ-003 The block SHALL have localparam cw = $clog2(credits+1), meaning credit counter width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on posedge clk.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port c_srdy, input, 1, meaning upstream has valid data (typically one p_srdy lane of a mirror/fork stage).
REQ-007 The block SHALL have port c_drdy, output, 1, meaning the block accepts c_data this cycle.
REQ-008 The block SHALL have port c_data, input, width, the upstream payload.
REQ-009 The block SHALL have port p_vld, output, 1, a one-cycle valid pulse per transferred word toward the credit-based receiver.
REQ-010 The block SHALL have port p_data, output, width, the registered payload.
REQ-011 The block SHALL have port p_credit, input, 1, a one-cycle pulse returning one credit from the receiver.
REQ-012 The block SHALL have port credit_cnt, output, cw, the current available credit count.
REQ-013 The block SHALL have port err_ovf, output, 1, a sticky credit-overflow error flag.

Function
REQ-014 The block SHALL assert c_drdy = (credit_cnt != 0), driven only from registered state, with no combinational path from c_srdy, c_data or p_credit.
REQ-015 A transfer (xfer) SHALL occur in any cycle where c_srdy & c_drdy.
REQ-016 On xfer, the block SHALL register c_data into p_data and set p_vld=1 on the next cycle (latency exactly 1 cycle).
REQ-017 p_vld SHALL be 0 in any cycle not immediately following an xfer; back-to-back xfers SHALL produce back-to-back p_vld pulses at full throughput while credits remain.
REQ-018 p_data SHALL hold its last value when p_vld=0.
REQ-019 Counter update SHALL be: next credit_cnt = credit_cnt - xfer + p_credit, evaluated in a single cycle.
REQ-020 When xfer and p_credit occur in the same cycle, credit_cnt SHALL remain unchanged and err_ovf SHALL not be set, including at credit_cnt==credits.
REQ-021 When credit_cnt==0 and p_credit=1, next credit_cnt SHALL be 1, so c_drdy rises the following cycle and there is no same-cycle bypass.
REQ-022 When p_credit=1, no xfer occurs, and credit_cnt==credits, credit_cnt SHALL saturate at credits and err_ovf SHALL be set to 1.
REQ-023 err_ovf SHALL remain 1 until reset; no other event SHALL clear it.
REQ-024 credit_cnt SHALL never exceed credits nor underflow below 0 under any input sequence.
REQ-025 The block SHALL ignore c_data whenever no xfer occurs.

Reset
REQ-026 Assertion of reset_n=0 SHALL immediately, without waiting for a clock edge, force p_vld=0, p_data=0, credit_cnt=credits and err_ovf=0, and thereby c_drdy=1.
REQ-027 Reset asserted mid-stream SHALL drop any pending p_vld pulse, and no output pulse SHALL be generated for an xfer in the cycle reset is applied.
REQ-028 After reset_n deasserts, the first posedge SHALL accept a transfer if c_srdy=1.

Verification
REQ-029 The bench SHALL cover credits=4 with c_srdy held at 1 for 6 cycles and no p_credit -> exactly 4 p_vld pulses on consecutive cycles, data in order, credit_cnt 4->0, c_drdy=0 afterwards.
REQ-030 The bench SHALL cover credit_cnt=0 followed by a single p_credit pulse -> credit_cnt=1 and c_drdy=1 the next cycle, then one xfer and credit_cnt=0.
REQ-031 The bench SHALL cover simultaneous xfer and p_credit at credit_cnt=4 -> credit_cnt stays 4, err_ovf stays 0, and p_vld=1 the next cycle.
REQ-032 The bench SHALL cover a p_credit pulse at credit_cnt=4 with c_srdy=0 -> credit_cnt stays 4, err_ovf=1 and remains 1 for 10 subsequent cycles.
REQ-033 The bench SHALL cover reset_n pulsed low between clock edges during streaming (c_data=8'hA5) -> p_vld=0, p_data=0, credit_cnt=4 and err_ovf=0 asynchronously.
REQ-034 The bench SHALL cover random c_srdy and p_credit over 10k cycles with a receiver model holding 4 slots -> no receiver overflow, data order preserved, and credit_cnt equal to credits minus words outstanding at every cycle.
